// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter steering a 74F153 dual 4:1 mux: select settles before enables drop.
// Optional forced-release timeout is compiled in with MUX4_RR_ARBITER_TIMEOUT_EN.
module mux4_rr_arbiter #(
    parameter int SETTLE_CYCLES = 1,
    parameter int HOLD_MAX      = 8
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [3:0] REQ,
    output logic [3:0] GNT,
    output logic       S0,
    output logic       S1,
    output logic       Ea_N,
    output logic       Eb_N,
    output logic       BUSY,
    output logic       TIMEOUT
);

    generate
        if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 15) begin : g_bad_settle
            $error("SETTLE_CYCLES out of range 1..15");
        end
        if (HOLD_MAX < 1 || HOLD_MAX > 255) begin : g_bad_hold
            $error("HOLD_MAX out of range 1..255");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, SETTLE, GRANT} state_t;

    state_t     state, state_nx;
    logic [1:0] ptr, ptr_nx;
    logic [1:0] sel, sel_nx;      // latched winner; drives the mux select
    logic [3:0] gnt_nx;
    logic       en_n, en_n_nx;
    logic       busy_nx;
    logic [3:0] scnt, scnt_nx;
    logic [1:0] pick, idx;
    logic       found;
    logic       drop;

`ifdef MUX4_RR_ARBITER_TIMEOUT_EN
    logic [7:0] hcnt, hcnt_nx;
    logic       to_nx;
`endif

    // First requester at or after the pointer, wrapping mod 4.
    always_comb begin
        pick  = ptr;
        idx   = ptr;
        found = 1'b0;
        for (int i = 0; i < 4; i++) begin
            idx = ptr + 2'(i);
            if (!found && REQ[idx]) begin
                pick  = idx;
                found = 1'b1;
            end
        end
    end

    always_comb begin
        state_nx = state;
        ptr_nx   = ptr;
        sel_nx   = sel;
        gnt_nx   = GNT;
        en_n_nx  = en_n;
        scnt_nx  = scnt;
        drop     = 1'b0;
`ifdef MUX4_RR_ARBITER_TIMEOUT_EN
        hcnt_nx  = hcnt;
        to_nx    = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (|REQ) begin
                    sel_nx   = pick;
                    scnt_nx  = 4'(SETTLE_CYCLES);
                    state_nx = SETTLE;
                end
            end
            SETTLE: begin
                if (!REQ[sel]) begin
                    state_nx = IDLE;
                    scnt_nx  = 4'd0;
                end else if (scnt <= 4'd1) begin
                    state_nx = GRANT;
                    gnt_nx   = 4'b0001 << sel;
                    en_n_nx  = 1'b0;
                    scnt_nx  = 4'd0;
`ifdef MUX4_RR_ARBITER_TIMEOUT_EN
                    hcnt_nx  = 8'd1;
`endif
                end else begin
                    scnt_nx = scnt - 4'd1;
                end
            end
            GRANT: begin
                drop = !REQ[sel];
`ifdef MUX4_RR_ARBITER_TIMEOUT_EN
                if (REQ[sel] && hcnt >= 8'(HOLD_MAX)) begin
                    drop  = 1'b1;
                    to_nx = 1'b1;
                end else begin
                    hcnt_nx = hcnt + 8'd1;
                end
`endif
                if (drop) begin
                    state_nx = IDLE;
                    gnt_nx   = 4'b0000;
                    en_n_nx  = 1'b1;
                    ptr_nx   = sel + 2'd1;
`ifdef MUX4_RR_ARBITER_TIMEOUT_EN
                    hcnt_nx  = 8'd0;
`endif
                end
            end
            default: begin
                state_nx = IDLE;
                gnt_nx   = 4'b0000;
                en_n_nx  = 1'b1;
            end
        endcase
        busy_nx = (state_nx != IDLE);
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= IDLE;
            ptr   <= 2'd0;
            sel   <= 2'd0;
            GNT   <= 4'b0000;
            en_n  <= 1'b1;
            BUSY  <= 1'b0;
            scnt  <= 4'd0;
        end else begin
            state <= state_nx;
            ptr   <= ptr_nx;
            sel   <= sel_nx;
            GNT   <= gnt_nx;
            en_n  <= en_n_nx;
            BUSY  <= busy_nx;
            scnt  <= scnt_nx;
        end
    end

`ifdef MUX4_RR_ARBITER_TIMEOUT_EN
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            hcnt    <= 8'd0;
            TIMEOUT <= 1'b0;
        end else begin
            hcnt    <= hcnt_nx;
            TIMEOUT <= to_nx;
        end
    end
`else
    assign TIMEOUT = 1'b0;
`endif

    assign S0   = sel[0];
    assign S1   = sel[1];
    assign Ea_N = en_n;
    assign Eb_N = en_n;

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Scoreboard bench for mux4_rr_arbiter: stimulus queues per-cycle expectations, a negedge monitor checks them.
// Unit A uses SETTLE_CYCLES=1/HOLD_MAX=4, unit B uses SETTLE_CYCLES=3.
module tb_mux4_rr_arbiter;

    typedef struct {
        int         u;
        logic [3:0] g;
        logic [1:0] s;
        logic       en;
        logic       busy;
        logic       to;
        string      nm;
    } exp_t;

    logic       CLK;
    logic       RST;
    logic [3:0] req_a, req_b;
    logic [3:0] gnt_a, gnt_b;
    logic       s0_a, s1_a, ea_a, eb_a, busy_a, to_a;
    logic       s0_b, s1_b, ea_b, eb_b, busy_b, to_b;

    exp_t sb[$];
    exp_t m;
    int   vectors     = 0;
    int   miscompares = 0;
    logic [9:0] got, want;
    logic [1:0] prev_sel_a = 2'd0, prev_sel_b = 2'd0;

    mux4_rr_arbiter #(.SETTLE_CYCLES(1), .HOLD_MAX(4)) u_a (
        .CLK(CLK), .RST(RST), .REQ(req_a), .GNT(gnt_a), .S0(s0_a), .S1(s1_a),
        .Ea_N(ea_a), .Eb_N(eb_a), .BUSY(busy_a), .TIMEOUT(to_a)
    );

    mux4_rr_arbiter #(.SETTLE_CYCLES(3), .HOLD_MAX(8)) u_b (
        .CLK(CLK), .RST(RST), .REQ(req_b), .GNT(gnt_b), .S0(s0_b), .S1(s1_b),
        .Ea_N(ea_b), .Eb_N(eb_b), .BUSY(busy_b), .TIMEOUT(to_b)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // Monitor: one expectation per negedge while the queue holds any, plus structural invariants.
    always @(negedge CLK) begin
        if (sb.size() > 0) begin
            m    = sb.pop_front();
            got  = (m.u == 0) ? {gnt_a, s1_a, s0_a, ea_a, eb_a, busy_a, to_a}
                              : {gnt_b, s1_b, s0_b, ea_b, eb_b, busy_b, to_b};
            want = {m.g, m.s, m.en, m.en, m.busy, m.to};
            vectors++;
            if (got !== want) begin
                miscompares++;
                $display("FAIL %s: got gnt=%b s=%b ea/eb=%b%b busy=%b to=%b, expected gnt=%b s=%b en_n=%b busy=%b to=%b",
                         m.nm, got[9:6], got[5:4], got[3], got[2], got[1], got[0],
                         m.g, m.s, m.en, m.busy, m.to);
            end
        end
        if (!$onehot0(gnt_a) || !$onehot0(gnt_b)) begin
            miscompares++;
            $display("FAIL onehot: gnt_a=%b gnt_b=%b, required zero- or one-hot", gnt_a, gnt_b);
        end
        if (ea_a !== eb_a || ea_b !== eb_b) begin
            miscompares++;
            $display("FAIL enables_equal: a=%b%b b=%b%b, required equal pairs", ea_a, eb_a, ea_b, eb_b);
        end
        if (!ea_a && {s1_a, s0_a} != prev_sel_a) begin
            miscompares++;
            $display("FAIL bbm_a: select %0d->%0d with enables low, required stable", prev_sel_a, {s1_a, s0_a});
        end
        if (!ea_b && {s1_b, s0_b} != prev_sel_b) begin
            miscompares++;
            $display("FAIL bbm_b: select %0d->%0d with enables low, required stable", prev_sel_b, {s1_b, s0_b});
        end
        prev_sel_a = {s1_a, s0_a};
        prev_sel_b = {s1_b, s0_b};
    end

    task automatic push(input int u, input logic [3:0] g, input logic [1:0] s,
                        input logic en, input logic busy, input logic to, input string nm);
        exp_t e;
        e.u = u; e.g = g; e.s = s; e.en = en; e.busy = busy; e.to = to; e.nm = nm;
        sb.push_back(e);
    endtask

    // Drive REQ for the next edge and queue what the outputs must be after it.
    task automatic tick(input int u, input logic [3:0] r, input logic [3:0] g, input logic [1:0] s,
                        input logic en, input logic busy, input logic to, input string nm);
        if (u == 0) req_a = r; else req_b = r;
        push(u, g, s, en, busy, to, nm);
        @(posedge CLK);
        @(negedge CLK);
        #1;
    endtask

    task automatic serve(input int u, input logic [3:0] r, input int w, input int ns,
                         input int hold, input string nm);
        logic [3:0] g;
        g = 4'b0001;
        g = g << w;
        repeat (ns) tick(u, r, 4'b0000, 2'(w), 1'b1, 1'b1, 1'b0, {nm, " settle"});
        repeat (hold) tick(u, r, g, 2'(w), 1'b0, 1'b1, 1'b0, {nm, " grant"});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        RST = 1'b1; req_a = 4'b0000; req_b = 4'b0000;
        @(negedge CLK); #1;
        tick(0, 4'b0000, 4'b0000, 2'd0, 1'b1, 1'b0, 1'b0, "reset state");
        RST = 1'b0;

        // Single request: select after one edge, grant and enables after two.
        tick(0, 4'b0001, 4'b0000, 2'd0, 1'b1, 1'b1, 1'b0, "single settle");
        tick(0, 4'b0001, 4'b0001, 2'd0, 1'b0, 1'b1, 1'b0, "single grant");
        tick(0, 4'b0001, 4'b0001, 2'd0, 1'b0, 1'b1, 1'b0, "single hold");

        // Reset lands between edges while granted.
        @(posedge CLK); #2;
        RST = 1'b1; req_a = 4'b0000;
        push(0, 4'b0000, 2'd0, 1'b1, 1'b0, 1'b0, "async reset mid grant");
        @(negedge CLK); #1;
        tick(0, 4'b0000, 4'b0000, 2'd0, 1'b1, 1'b0, 1'b0, "reset held");
        RST = 1'b0;

        // All four requesting: rotation 0,1,2,3,0 with one idle cycle between grants.
        serve(0, 4'b1111, 0, 1, 3, "rr0");
        tick(0, 4'b1110, 4'b0000, 2'd0, 1'b1, 1'b0, 1'b0, "rr0 release");
        serve(0, 4'b1110, 1, 1, 3, "rr1");
        tick(0, 4'b1100, 4'b0000, 2'd1, 1'b1, 1'b0, 1'b0, "rr1 release");
        serve(0, 4'b1100, 2, 1, 3, "rr2");
        tick(0, 4'b1000, 4'b0000, 2'd2, 1'b1, 1'b0, 1'b0, "rr2 release");
        serve(0, 4'b1000, 3, 1, 3, "rr3");
        tick(0, 4'b0111, 4'b0000, 2'd3, 1'b1, 1'b0, 1'b0, "rr3 release");
        serve(0, 4'b0111, 0, 1, 3, "rr0 again");
        tick(0, 4'b0000, 4'b0000, 2'd0, 1'b1, 1'b0, 1'b0, "rr0 again release");

        // Three-cycle settle aborted by a short pulse; pointer must still favour 0.
        tick(1, 4'b0100, 4'b0000, 2'd2, 1'b1, 1'b1, 1'b0, "abort settle 1");
        tick(1, 4'b0100, 4'b0000, 2'd2, 1'b1, 1'b1, 1'b0, "abort settle 2");
        tick(1, 4'b0000, 4'b0000, 2'd2, 1'b1, 1'b0, 1'b0, "abort to idle");
        tick(1, 4'b0000, 4'b0000, 2'd2, 1'b1, 1'b0, 1'b0, "abort stays idle");
        serve(1, 4'b1111, 0, 3, 1, "post abort ptr0");
        tick(1, 4'b0000, 4'b0000, 2'd0, 1'b1, 1'b0, 1'b0, "post abort release");

        RST = 1'b1;
        tick(0, 4'b0000, 4'b0000, 2'd0, 1'b1, 1'b0, 1'b0, "reset before hold test");
        RST = 1'b0;
`ifdef MUX4_RR_ARBITER_TIMEOUT_EN
        serve(0, 4'b0011, 0, 1, 4, "timeout hold");
        tick(0, 4'b0011, 4'b0000, 2'd0, 1'b1, 1'b0, 1'b1, "timeout pulse");
        serve(0, 4'b0011, 1, 1, 2, "after timeout");
        tick(0, 4'b0000, 4'b0000, 2'd1, 1'b1, 1'b0, 1'b0, "after timeout release");
`else
        serve(0, 4'b0011, 0, 1, 6, "no timeout hold");
        tick(0, 4'b0010, 4'b0000, 2'd0, 1'b1, 1'b0, 1'b0, "no timeout release");
        serve(0, 4'b0010, 1, 1, 1, "no timeout next");
        tick(0, 4'b0000, 4'b0000, 2'd1, 1'b1, 1'b0, 1'b0, "no timeout next release");
`endif

        repeat (2) @(negedge CLK);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
